rgb_fade_ctrl: RTL and testbench

Fade controller for the RGB mixer's three PWM channels. It accepts per-channel target duty values over a valid/ready interface and ramps each channel's live duty toward its target in fixed steps at a programmable rate. New duty values reach the PWM generator only at PWM period boundaries, so the outputs never glitch. It sits between the host/button front-end and the PWM datapath.

---
 rtl/rgb_mixer_pkg.sv | 20 ++
 rtl/rgb_tick_gen.sv | 31 +++
 rtl/rgb_fade_ctrl.sv | 124 ++++++++++++
 tb/tb_rgb_fade_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer: duty width, channel codes, fade FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rgb_mixer_pkg;

    localparam int DUTY_W = 8;
    localparam int NUM_CH = 3;

    localparam logic [1:0] CH_R       = 2'd0;
    localparam logic [1:0] CH_G       = 2'd1;
    localparam logic [1:0] CH_B       = 2'd2;
    localparam logic [1:0] CH_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        FLUSH = 2'd2
    } fade_state_e;

endpackage

// File: rtl/rgb_tick_gen.sv
// Free-running divider producing a one-cycle step_tick every CLK_FREQ/STEP_FREQ cycles.
// Latency: tick asserted while the counter sits at its last value.
// Backpressure: none, runs unconditionally.
module rgb_tick_gen #(
    parameter int CLK_FREQ  = 50000000,
    parameter int STEP_FREQ = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic step_tick
);

    localparam int TICK_DIV = CLK_FREQ / STEP_FREQ;
    localparam int CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign step_tick = (cnt == LAST);

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Ramps three PWM duty values toward host targets in fixed steps; flushes to PWM on pwm_sync.
// Latency: target write 1 cycle; duty moves per step_tick, visible at the next pwm_sync.
// Backpressure: none, tgt_ready is constant 1; writes accepted in every state.
module rgb_fade_ctrl #(
    parameter int DUTY_W    = rgb_mixer_pkg::DUTY_W,
    parameter int CLK_FREQ  = 50000000,
    parameter int STEP_FREQ = 1000,
    parameter int STEP      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [1:0]        tgt_chan,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              pwm_sync,
    output logic [DUTY_W-1:0] duty0,
    output logic [DUTY_W-1:0] duty1,
    output logic [DUTY_W-1:0] duty2,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import rgb_mixer_pkg::*;

    localparam logic [DUTY_W-1:0]        STEP_V = DUTY_W'(STEP);
    localparam logic signed [DUTY_W:0]   STEP_S = (DUTY_W + 1)'(STEP);

    logic [DUTY_W-1:0] tgt  [NUM_CH];
    logic [DUTY_W-1:0] cur  [NUM_CH];
    logic [DUTY_W-1:0] duty [NUM_CH];
    logic              step_tick;
    logic              wr;
    logic              all_eq;
    fade_state_e       state;

    // Signed diff one bit wider than duty, so the +/-STEP move can never wrap.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] c,
                                                      input logic [DUTY_W-1:0] t);
        logic signed [DUTY_W:0] diff;
        diff = $signed({1'b0, t}) - $signed({1'b0, c});
        if (diff > STEP_S)       return c + STEP_V;
        else if (diff < -STEP_S) return c - STEP_V;
        else                     return t;
    endfunction

    rgb_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .STEP_FREQ (STEP_FREQ)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .step_tick (step_tick)
    );

    assign tgt_ready = 1'b1;
    assign wr        = tgt_valid & tgt_ready;

    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tgt[i] != cur[i]) all_eq = 1'b0;
        end
    end

    // Non-blocking update order gives old-target stepping and pre-step flushing for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i]  <= '0;
                cur[i]  <= '0;
                duty[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr && (tgt_chan == 2'(i))) tgt[i] <= tgt_duty;
                if (step_tick)                 cur[i] <= step_toward(cur[i], tgt[i]);
                if (pwm_sync)                  duty[i] <= cur[i];
            end
            err <= wr && (tgt_chan == CH_ILLEGAL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!all_eq) begin
                        state <= RAMP;
                        busy  <= 1'b1;
                    end
                end
                RAMP: begin
                    if (all_eq) state <= FLUSH;
                end
                FLUSH: begin
                    if (!all_eq) begin
                        state <= RAMP;
                    end else if (pwm_sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign duty0 = duty[0];
    assign duty1 = duty[1];
    assign duty2 = duty[2];

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Bench for rgb_fade_ctrl: directed scenarios plus random writes against a cycle model.
module tb_rgb_fade_ctrl;

    localparam int DW       = 8;
    localparam int STEP     = 10;
    localparam int TDIV     = 50;
    localparam int SYNC_PER = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tgt_valid = 1'b0;
    logic          tgt_ready;
    logic [1:0]    tgt_chan = 2'd0;
    logic [DW-1:0] tgt_duty = '0;
    logic          pwm_sync = 1'b0;
    logic [DW-1:0] duty0, duty1, duty2;
    logic          busy, done, err;

    rgb_fade_ctrl #(
        .DUTY_W    (DW),
        .CLK_FREQ  (50000000),
        .STEP_FREQ (1000000),
        .STEP      (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_chan  (tgt_chan),
        .tgt_duty  (tgt_duty),
        .pwm_sync  (pwm_sync),
        .duty0     (duty0),
        .duty1     (duty1),
        .duty2     (duty2),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: targets, live values, flushed values, and a settle phase
    // (0 = settled, 1 = ramping, 2 = settled but not yet flushed).
    int m_tgt [3];
    int m_cur [3];
    int m_duty[3];
    int m_phase;
    int m_busy, m_done, m_err;
    int n_edges;
    int gcnt = 0;
    int done_seen = 0;
    int err_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int toward(input int c, input int t);
        if (t > c + STEP) return c + STEP;
        if (t < c - STEP) return c - STEP;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_tgt[i] = 0; m_cur[i] = 0; m_duty[i] = 0;
        end
        m_phase = 0; m_busy = 0; m_done = 0; m_err = 0;
        n_edges = 0;
    endtask

    task automatic check_outputs();
        chk("duty0", 32'(duty0), 32'(m_duty[0]));
        chk("duty1", 32'(duty1), 32'(m_duty[1]));
        chk("duty2", 32'(duty2), 32'(m_duty[2]));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("tgt_ready", 32'(tgt_ready), 32'd1);
    endtask

    // Called at a negedge: drive inputs, advance model across the posedge, compare at next negedge.
    task automatic cycle(input bit v, input int ch, input int d);
        bit sync, tick, all_eq;
        sync = (gcnt % SYNC_PER) == SYNC_PER - 1;
        gcnt++;
        tgt_valid = v;
        tgt_chan  = 2'(ch);
        tgt_duty  = 8'(d);
        pwm_sync  = sync;
        @(posedge clk);
        tick = (n_edges % TDIV) == TDIV - 1;
        n_edges++;
        all_eq = 1'b1;
        for (int i = 0; i < 3; i++) if (m_tgt[i] != m_cur[i]) all_eq = 1'b0;
        m_done = 0;
        case (m_phase)
            0:       if (!all_eq) m_phase = 1;
            1:       if (all_eq) m_phase = 2;
            default: if (!all_eq) m_phase = 1;
                     else if (sync) begin m_phase = 0; m_done = 1; end
        endcase
        m_busy = (m_phase != 0) ? 1 : 0;
        m_err  = (v && ch == 3) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            if (sync) m_duty[i] = m_cur[i];
            if (tick) m_cur[i] = toward(m_cur[i], m_tgt[i]);
            if (v && ch == i) m_tgt[i] = d;
        end
        @(negedge clk);
        tgt_valid = 1'b0;
        pwm_sync  = 1'b0;
        check_outputs();
        done_seen += int'(done === 1'b1);
        err_seen  += int'(err === 1'b1);
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, 0, 0);
    endtask

    initial begin
        int d0, e0;
        bit hit;

        // Reset / idle
        model_reset();
        repeat (5) @(negedge clk);
        check_outputs();
        rst = 1'b0;
        idle(150);
        chk("idle_no_done", 32'(done_seen), 32'd0);

        // Single ramp up on channel 0
        d0 = done_seen;
        cycle(1'b1, 0, 35);
        idle(400);
        chk("ramp_up_done_cnt", 32'(done_seen - d0), 32'd1);
        chk("ramp_up_duty0", 32'(duty0), 32'd35);

        // Ramp down to 0 on channel 1 after bringing it to 35
        cycle(1'b1, 1, 35);
        idle(400);
        d0 = done_seen;
        cycle(1'b1, 1, 0);
        idle(400);
        chk("ramp_down_done_cnt", 32'(done_seen - d0), 32'd1);
        chk("ramp_down_duty1", 32'(duty1), 32'd0);

        // Retarget channel 2 mid-ramp once it has reached 30
        d0 = done_seen;
        cycle(1'b1, 2, 200);
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            if (m_cur[2] == 30) hit = 1'b1;
            else cycle(1'b0, 0, 0);
        end
        chk("retarget_reach30", 32'(hit), 32'd1);
        chk("retarget_busy", 32'(busy), 32'd1);
        cycle(1'b1, 2, 15);
        idle(400);
        chk("retarget_done_cnt", 32'(done_seen - d0), 32'd1);
        chk("retarget_duty2", 32'(duty2), 32'd15);

        // Write landing on the step_tick cycle
        while ((n_edges % TDIV) != TDIV - 1) cycle(1'b0, 0, 0);
        cycle(1'b1, 0, 100);
        idle(800);
        chk("simul_duty0", 32'(duty0), 32'd100);

        // Illegal channel
        e0 = err_seen;
        cycle(1'b1, 3, 77);
        idle(200);
        chk("illegal_err_cnt", 32'(err_seen - e0), 32'd1);
        chk("illegal_duty0", 32'(duty0), 32'd100);
        chk("illegal_duty1", 32'(duty1), 32'd0);
        chk("illegal_duty2", 32'(duty2), 32'd15);

        // Randomized writes
        for (int k = 0; k < 40; k++) begin
            cycle(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            idle(int'($urandom_range(0, 120)));
        end
        idle(1500);
        chk("random_settled_busy", 32'(busy), 32'd0);

        // Async reset mid-ramp
        cycle(1'b1, 0, 250);
        cycle(1'b1, 1, 5);
        idle(120);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (3) @(negedge clk);
        check_outputs();
        rst = 1'b0;
        d0 = done_seen;
        idle(300);
        chk("post_reset_done_cnt", 32'(done_seen - d0), 32'd0);
        chk("post_reset_duty0", 32'(duty0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
